// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the core
// load/store unit (port 0) and a debug/loader master (port 1).
// One access is granted per cycle and drives the memory port directly.
// Read data is routed back to its requester READ_LAT cycles later through
// a small {valid, owner} return pipeline.
// Optional build macro DMEM_ARBITER_CORE_PRIO_EN: fixed priority to the
// core with a starvation counter for the debug port. When the macro is not
// defined, contested cycles are resolved round-robin.
module dmem_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 32,
  parameter int READ_LAT   = 1,
  parameter int STARVE_MAX = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [AW-1:0]     m0_addr,
  input  logic [DW-1:0]     m0_wdata,
  input  logic [DW/8-1:0]   m0_wstrb,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DW-1:0]     m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [AW-1:0]     m1_addr,
  input  logic [DW-1:0]     m1_wdata,
  input  logic [DW/8-1:0]   m1_wstrb,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DW-1:0]     m1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  output logic [DW/8-1:0]   mem_wstrb,
  input  logic [DW-1:0]     mem_rdata
);

  localparam int SW   = DW / 8;
  localparam int LAST = READ_LAT - 1;

  logic          gnt0;
  logic          gnt1;
  logic          gnt_any;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic [SW-1:0] sel_wstrb;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          rd_issue;

`ifdef DMEM_ARBITER_CORE_PRIO_EN
  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_cnt;
  logic          starved;

  assign starved = (starve_cnt >= CW'(STARVE_MAX));

  // Core has priority unless the debug port has waited STARVE_MAX cycles;
  // nothing is granted while reset is high.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (m0_req && m1_req) begin
        if (starved) gnt1 = 1'b1;
        else         gnt0 = 1'b1;
      end else if (m0_req) begin
        gnt0 = 1'b1;
      end else if (m1_req) begin
        gnt1 = 1'b1;
      end
    end
  end

  // Count consecutive denied debug cycles, saturating at the threshold,
  // and clear once the debug port is served.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (gnt1) begin
      starve_cnt <= '0;
    end else if (m1_req && !starved) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  logic last_owner;

  // Round-robin: on a tie the port that did not win last time is granted;
  // nothing is granted while reset is high.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (m0_req && m1_req) begin
        if (last_owner) gnt0 = 1'b1;
        else            gnt1 = 1'b1;
      end else if (m0_req) begin
        gnt0 = 1'b1;
      end else if (m1_req) begin
        gnt1 = 1'b1;
      end
    end
  end

  // Remember the most recent winner; reset value 1 lets the core win the
  // first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner <= 1'b1;
    end else if (gnt0) begin
      last_owner <= 1'b0;
    end else if (gnt1) begin
      last_owner <= 1'b1;
    end
  end
`endif

  assign gnt_any = gnt0 | gnt1;
  assign m0_gnt  = gnt0;
  assign m1_gnt  = gnt1;

  // Steer the winning port onto the memory; an idle port keeps address and
  // data stable and forces write enable and strobes low. A write enable
  // that is not a clean 1 takes the read path.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = addr_q;
    sel_wdata = wdata_q;
    sel_wstrb = '0;
    if (gnt0) begin
      if (m0_we) sel_we = 1'b1;
      sel_addr  = m0_addr;
      sel_wdata = m0_wdata;
      sel_wstrb = m0_wstrb;
    end else if (gnt1) begin
      if (m1_we) sel_we = 1'b1;
      sel_addr  = m1_addr;
      sel_wdata = m1_wdata;
      sel_wstrb = m1_wstrb;
    end
  end

  // Hold the last driven address and data for idle cycles.
  always_ff @(posedge clk) begin
    if (gnt_any) begin
      addr_q  <= sel_addr;
      wdata_q <= sel_wdata;
    end
  end

  assign mem_en    = gnt_any;
  assign mem_we    = sel_we;
  assign mem_addr  = sel_addr;
  assign mem_wdata = sel_wdata;
  assign mem_wstrb = sel_wstrb;
  assign rd_issue  = gnt_any & ~sel_we;

  // ---- return pipeline stage 0 .. LAST: {valid, owner} per granted read
  logic [READ_LAT-1:0] vld_p;
  logic [READ_LAT-1:0] own_p;

  // Valid bits shift one stage per cycle; reset drops in-flight reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= rd_issue;
      for (int i = 1; i < READ_LAT; i++) begin
        vld_p[i] <= vld_p[i-1];
      end
    end
  end

  // Owner tags travel alongside the valid bits.
  always_ff @(posedge clk) begin
    own_p[0] <= gnt1;
    for (int i = 1; i < READ_LAT; i++) begin
      own_p[i] <= own_p[i-1];
    end
  end

  // ---- return stage: memory data lines up with the last pipeline stage
  logic          rv0;
  logic          rv1;
  logic [DW-1:0] rdata0_q;
  logic [DW-1:0] rdata1_q;

  assign rv0 = ~rst & vld_p[LAST] & ~own_p[LAST];
  assign rv1 = ~rst & vld_p[LAST] &  own_p[LAST];

  // Capture returned data per port so it holds until that port's next pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (rv0) rdata0_q <= mem_rdata;
      if (rv1) rdata1_q <= mem_rdata;
    end
  end

  assign m0_rvalid = rv0;
  assign m1_rvalid = rv1;
  assign m0_rdata  = rv0 ? mem_rdata : rdata0_q;
  assign m1_rdata  = rv1 ? mem_rdata : rdata1_q;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter sharing the core's single-port data memory between the core load/store unit (port 0) and a debug/loader master (port 1).
- The debug/loader master preloads and inspects data memory while the core runs.
- Grants one access per cycle, drives the memory port, and routes read data back to the owning requester after a fixed memory latency.
- Sits between the core, the debug master and the data memory macro.

Parameters:
- AW, 8, word address width (256-word memory).
- DW, 32, data width; must be a multiple of 8.
- READ_LAT, 1, memory read latency in cycles (1..4).
- STARVE_MAX, 15, number of consecutive denied cycles after which a waiting requester is forced to win. Used only with the optional feature.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous active-high reset.
- m0_req  in  1  core request; held stable until granted.
- m0_we  in  1  core write enable (1 = write, 0 = read).
- m0_addr  in  AW  core word address.
- m0_wdata  in  DW  core write data.
- m0_wstrb  in  DW/8  core byte strobes.
- m0_gnt  out  1  core request accepted this cycle.
- m0_rvalid  out  1  core read data valid.
- m0_rdata  out  DW  core read data.
- m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb, m1_gnt, m1_rvalid, m1_rdata: same as the m0_* ports, for the debug master.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_wstrb  out  DW/8  memory byte strobes.
- mem_rdata  in  DW  memory read data, valid READ_LAT cycles after a read strobe.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset values: all gnt, rvalid and mem_en outputs 0; rdata 0; last_owner=1 (port 0 wins the first tie); return pipeline cleared; starve counters 0.
- Arbitration (combinational each cycle):
  - Only one req: that port is granted.
  - Both req: round-robin; grant the port not equal to last_owner.
  - last_owner updates to the granted port on every grant.
- Grant timing: gnt is asserted in the same cycle as req when selected. A request completes on the cycle req & gnt is high. The requester may change or drop req on the next cycle.
- Memory drive:
  - mem_en = any grant.
  - mem_we, mem_addr, mem_wdata and mem_wstrb are muxed from the granted port.
  - When nothing is granted: mem_we=0, mem_wstrb=0, and addr/data hold their last value.
- Writes: complete at the grant; no response is returned.
- Reads: the return pipeline has READ_LAT stages of {valid, owner}.
  - Stage 0 is loaded on a granted read.
  - At the last stage, the owner's rvalid is pulsed for exactly 1 cycle and its rdata is registered from mem_rdata. rdata holds until the next rvalid for that port.
  - Reads return in grant order; there are no stalls. Back-to-back reads from alternating ports return alternating rvalid pulses.
- Same-address hazard: a write granted in cycle N followed by a read granted in cycle N+1 returns the new data; the memory guarantees write-first.
- Ownership: the non-granted port sees gnt=0 and must hold req and its payload.
- Reset mid-operation: in-flight reads are discarded and no rvalid follows. A write granted in the same cycle that rst is high is not issued (mem_en forced 0 while rst).
- Illegal: a request with X on we is treated as a read (mem_we=0).

Optional Feature:
- Macro: DMEM_ARBITER_CORE_PRIO_EN.
- Defined:
  - Fixed priority to port 0.
  - A starve counter increments each cycle m1_req is high and not granted, and clears on an m1 grant.
  - When the counter reaches STARVE_MAX, port 1 wins the next contested cycle. The counter then clears.
  - last_owner is unused.
- Undefined: pure round-robin as above; no starve counter is instantiated.

Test Plan:
1. Reset, then m0 reads addr 0x10 alone -> m0_gnt same cycle; mem_en=1, mem_addr=0x10; m0_rvalid 1 cycle later (READ_LAT=1) with the preloaded 0xDEADBEEF; m1_rvalid stays 0.
2. m1 writes 0x12345678 to 0x20 with strobe 0xF, then m0 reads 0x20 the next cycle -> m0_rdata = 0x12345678.
3. Both req continuously for 6 cycles -> grants alternate 0,1,0,1,0,1; each rvalid goes to the correct port in grant order.
4. Partial write: strobe 0x3, data 0xAAAA5555 onto 0xFFFFFFFF -> readback 0xFFFF5555.
5. Read granted, then rst asserted during the next cycle with READ_LAT=2 -> no rvalid after reset; all outputs at reset values.
6. With DMEM_ARBITER_CORE_PRIO_EN and STARVE_MAX=3, both req continuously -> pattern 0,0,0,1,0,0,0,1; without the macro -> strict alternation.
